mux8_scanner: RTL and testbench
===============================

// Module: mux8_scanner
// PURPOSE
//  Sequencer that sits directly upstream of the 8-to-1 AND/OR mux (mux8).
//  - Drives the mux select S[2:0] through 0..7 and samples the mux output Y.
//  - Assembles the eight sampled bits into a parallel word.
//  - Presents the word to the consumer (Mastermind input/compare logic) on a Valid/Ack handshake.
//  - Gives the gate-level mux time to settle before each sample.
// PARAMETERS
//  SETTLE  2  cycles S is held stable before Y is sampled; legal range 1..15
//  CNT_W   4  width of the settle counter; must satisfy 2**CNT_W > SETTLE
// PORTS
//  Clk      in   1  rising-edge clock (single clock domain)
//  Reset_n  in   1  asynchronous, active-low reset
//  Start    in   1  request a scan; sampled only in IDLE, or in DONE together with Ack
//  Y        in   1  mux8 output
//  S        out  3  mux8 select
//  Word     out  8  completed scan; Word[k] = Y sampled while S==k
//  Valid    out  1  Word holds a completed scan; waiting for Ack
//  Ack      in   1  consumer accepts Word; meaningful only while Valid=1
//  Busy     out  1  1 in WAIT, i.e. a scan is in progress
// BEHAVIOUR
//  Reset (async, Reset_n=0): state=IDLE, S=0, Word=0, shift reg=0, cnt=0, Valid=0, Busy=0.
//    Reset mid-scan aborts the scan immediately; no partial Word is ever published.
//  FSM states: IDLE, WAIT, DONE.
//  IDLE: Start=1 at edge E0 -> WAIT; S=0, cnt=0, Busy=1 from E0.
//  WAIT: cnt increments each edge.
//    At the edge where cnt==SETTLE-1: capture Y into shift reg bit S; cnt=0.
//    If S!=7, S increments on that edge.
//    If S==7: copy the full shift reg (including this bit) into Word; go to DONE; Valid=1; Busy=0; S stays 7.
//  Timing: S==k held for exactly SETTLE cycles. Bit k captured at edge E0+(k+1)*SETTLE.
//    Valid rises at E0+8*SETTLE (16 cycles for SETTLE=2).
//  DONE: Valid and Word held stable until Ack=1 at an edge.
//    Ack only -> IDLE; Valid=0; S=0.
//    Ack with Start -> WAIT directly (back-to-back scan): Valid=0, S=0, cnt=0, Busy=1.
//  Word is updated only on the DONE transition. It never changes while Valid=1 or during a scan.
//  Start in WAIT, or in DONE without Ack: ignored; no queuing.
//  Ack outside DONE: ignored.
//  Y is used combinationally only at capture edges. Y changing mid-settle has no effect.
// CONFIGURATION
//  MUX8_SCAN_CHANGE_EN defined:
//    Adds output Changed (1 bit, reset 0) and an internal 8-bit last-word register (reset 0).
//    On the DONE transition: Changed = (new Word != last word); last word <= new Word.
//    Changed is held while Valid=1 and cleared when Ack is taken.
//  Macro undefined: no Changed port, no last-word register. All other behaviour identical.
// TESTING
//  T1 reset: Reset_n=0 with Start=1, Ack=1 -> S=0, Word=0, Valid=0, Busy=0; hold 5 cycles, no change.
//  T2 basic, SETTLE=2:
//    I=8'hA5, Start pulse at E0.
//    S holds 0,1,..,7 for 2 cycles each; Busy=1 for 16 cycles.
//    Valid=1 at E0+16 with Word=8'hA5.
//  T3 hold:
//    After T2, Ack=0 for 10 cycles and I changed to 8'hFF -> Valid stays 1, Word stays 8'hA5, S=7.
//    Ack=1 -> Valid=0, S=0, Word still 8'hA5.
//  T4 ignored inputs:
//    Start pulses at scan cycles 3 and 9 -> only one scan; Valid at E0+16.
//    Ack pulse during WAIT -> no effect.
//  T5 back-to-back:
//    In DONE, Ack=1 and Start=1 at the same edge with I=8'h3C.
//    Valid drops for 16 cycles, then returns with Word=8'h3C.
//  T6 abort + feature (MUX8_SCAN_CHANGE_EN):
//    Reset_n low during bit 4 -> all outputs return to reset values.
//    Scan 8'h5A -> Changed=1 (last word 0). Rescan 8'h5A -> Changed=0. Scan 8'h5B -> Changed=1.

Source files
------------

// File: rtl/mux8_scanner_if.sv
// Handshake/bus bundle between mux8_scanner, the mux8 it drives and the word consumer.
// Optional Changed signal exists only when MUX8_SCAN_CHANGE_EN is defined.
interface mux8_scanner_if;
  logic       Start;
  logic       Y;
  logic       Ack;
  logic [2:0] S;
  logic [7:0] Word;
  logic       Valid;
  logic       Busy;
`ifdef MUX8_SCAN_CHANGE_EN
  logic       Changed;

  modport master (
    input  Start, Y, Ack,
    output S, Word, Valid, Busy, Changed
  );
  modport slave (
    output Start, Y, Ack,
    input  S, Word, Valid, Busy, Changed
  );
`else
  modport master (
    input  Start, Y, Ack,
    output S, Word, Valid, Busy
  );
  modport slave (
    output Start, Y, Ack,
    input  S, Word, Valid, Busy
  );
`endif
endinterface

// File: rtl/mux8_scanner.sv
// Steps the mux8 select through 0..7, samples Y after a settle delay and publishes the 8-bit
// word on a Valid/Ack handshake. Define MUX8_SCAN_CHANGE_EN to add the Changed output.
module mux8_scanner #(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 4
) (
  input  logic           Clk,
  input  logic           Reset_n,
  mux8_scanner_if.master bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t           state_reg;
  logic [2:0]       s_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [7:0]       shift_reg;
  logic [7:0]       word_reg;
  logic             valid_reg;
  logic             busy_reg;
  logic             capture;
  logic [7:0]       full_word;

`ifdef MUX8_SCAN_CHANGE_EN
  logic [7:0]       last_word_reg;
  logic             changed_reg;
`endif

  assign capture   = (cnt_reg == CNT_W'(SETTLE - 1));
  // Final bit is still in flight at the last capture edge, so splice it in directly.
  assign full_word = {bus.Y, shift_reg[6:0]};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg     <= IDLE;
      s_reg         <= 3'd0;
      cnt_reg       <= '0;
      shift_reg     <= 8'd0;
      word_reg      <= 8'd0;
      valid_reg     <= 1'b0;
      busy_reg      <= 1'b0;
`ifdef MUX8_SCAN_CHANGE_EN
      last_word_reg <= 8'd0;
      changed_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.Start) begin
            state_reg <= WAIT;
            s_reg     <= 3'd0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end
        WAIT: begin
          if (capture) begin
            cnt_reg          <= '0;
            shift_reg[s_reg] <= bus.Y;
            if (s_reg == 3'd7) begin
              word_reg  <= full_word;
              state_reg <= DONE;
              valid_reg <= 1'b1;
              busy_reg  <= 1'b0;
`ifdef MUX8_SCAN_CHANGE_EN
              changed_reg   <= (full_word != last_word_reg);
              last_word_reg <= full_word;
`endif
            end else begin
              s_reg <= s_reg + 3'd1;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        DONE: begin
          if (bus.Ack) begin
            valid_reg <= 1'b0;
            s_reg     <= 3'd0;
`ifdef MUX8_SCAN_CHANGE_EN
            changed_reg <= 1'b0;
`endif
            if (bus.Start) begin
              state_reg <= WAIT;
              cnt_reg   <= '0;
              busy_reg  <= 1'b1;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.S     = s_reg;
  assign bus.Word  = word_reg;
  assign bus.Valid = valid_reg;
  assign bus.Busy  = busy_reg;
`ifdef MUX8_SCAN_CHANGE_EN
  assign bus.Changed = changed_reg;
`endif

endmodule

// File: tb/tb_mux8_scanner.sv
// Bench for mux8_scanner: models the mux8 as Y = I[S] and checks every cycle against
// expectations computed from elapsed cycles since the scan start edge.
module tb_mux8_scanner;
  localparam int SETTLE = 2;
  localparam int SCAN   = 8 * SETTLE;

  logic       Clk     = 1'b0;
  logic       Reset_n = 1'b0;
  logic [7:0] I       = 8'd0;

  mux8_scanner_if bus ();
  assign bus.Y = I[bus.S];

  mux8_scanner #(.SETTLE(SETTLE), .CNT_W(4)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus.master)
  );

  always #5 Clk = ~Clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_word = 8'd0;
  logic [7:0] last_word  = 8'd0;
  logic       exp_changed = 1'b0;

  typedef struct {
    logic [7:0] pat;
    bit         b2b;
    bit         noise;
    logic [7:0] exp_word;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int exp_s, input bit exp_busy, input bit exp_valid);
    chk({tag, "_S"}, 32'(bus.S), 32'(exp_s));
    chk({tag, "_Busy"}, 32'(bus.Busy), 32'(exp_busy));
    chk({tag, "_Valid"}, 32'(bus.Valid), 32'(exp_valid));
    chk({tag, "_Word"}, 32'(bus.Word), 32'(model_word));
`ifdef MUX8_SCAN_CHANGE_EN
    chk({tag, "_Changed"}, 32'(bus.Changed), 32'(exp_changed));
`endif
  endtask

  // Start edge is E0; edge E0+j captures bit j/SETTLE-1 whenever j is a multiple of SETTLE.
  task automatic run_scan(input logic [7:0] pat, input bit b2b, input bit noise, input bit rnd);
    logic [7:0] expw;
    expw      = 8'd0;
    bus.Start = 1'b1;
    bus.Ack   = b2b;
    I         = rnd ? 8'($urandom) : pat;
    tick();
    bus.Start   = 1'b0;
    bus.Ack     = 1'b0;
    exp_changed = 1'b0;
    check_all("start", 0, 1'b1, 1'b0);
    for (int j = 1; j <= SCAN; j++) begin
      if (rnd) I = 8'($urandom);
      if (noise && (j == 3 || j == 9)) begin
        bus.Start = 1'b1;
        bus.Ack   = 1'b1;
      end
      if (j % SETTLE == 0) expw[j / SETTLE - 1] = I[j / SETTLE - 1];
      if (j == SCAN) begin
        model_word  = expw;
        exp_changed = (expw != last_word);
        last_word   = expw;
      end
      tick();
      bus.Start = 1'b0;
      bus.Ack   = 1'b0;
      check_all("scan", (j < SCAN) ? j / SETTLE : 7, j < SCAN, j == SCAN);
    end
    $display("scan b2b=%0b noise=%0b rnd=%0b word=%h expected=%h valid=%0b",
             b2b, noise, rnd, bus.Word, expw, bus.Valid);
  endtask

  task automatic ack_idle();
    bus.Ack = 1'b1;
    tick();
    bus.Ack     = 1'b0;
    exp_changed = 1'b0;
    check_all("ack", 0, 1'b0, 1'b0);
    $display("ack word=%h valid=%0b busy=%0b", bus.Word, bus.Valid, bus.Busy);
  endtask

  initial begin
    bit b2b_flag;
    tbl[0] = '{8'h96, 1'b0, 1'b1, 8'h96};
    tbl[1] = '{8'h3C, 1'b1, 1'b0, 8'h3C};
    tbl[2] = '{8'h00, 1'b1, 1'b0, 8'h00};
    tbl[3] = '{8'hFF, 1'b0, 1'b0, 8'hFF};
    tbl[4] = '{8'h5A, 1'b1, 1'b1, 8'h5A};
    tbl[5] = '{8'h81, 1'b0, 1'b0, 8'h81};

    // Reset held with Start and Ack asserted
    bus.Start = 1'b1;
    bus.Ack   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_all("reset", 0, 1'b0, 1'b0);
      $display("reset cycle=%0d S=%0d valid=%0b busy=%0b", c, bus.S, bus.Valid, bus.Busy);
    end
    bus.Start = 1'b0;
    bus.Ack   = 1'b0;
    #2 Reset_n = 1'b1;
    tick();

    // Ack in IDLE is ignored
    bus.Ack = 1'b1;
    tick();
    bus.Ack = 1'b0;
    check_all("idle_ack", 0, 1'b0, 1'b0);

    // Basic scan then hold with Ack low, Start ignored in DONE without Ack
    run_scan(8'hA5, 1'b0, 1'b0, 1'b0);
    chk("basic_word", 32'(bus.Word), 32'h A5);
    I = 8'hFF;
    for (int c = 0; c < 10; c++) begin
      if (c == 5) bus.Start = 1'b1;
      tick();
      bus.Start = 1'b0;
      check_all("hold", 7, 1'b0, 1'b1);
    end
    $display("hold word=%h valid=%0b S=%0d", bus.Word, bus.Valid, bus.S);
    ack_idle();
    chk("after_ack_word", 32'(bus.Word), 32'h A5);

    // Table: ignored-input scans and back-to-back scans
    for (int i = 0; i < 6; i++) begin
      run_scan(tbl[i].pat, tbl[i].b2b, tbl[i].noise, 1'b0);
      chk("tbl_word", 32'(bus.Word), 32'(tbl[i].exp_word));
      if (i == 5 || !tbl[i + 1].b2b) ack_idle();
    end

    // Randomized scans with Y changing every cycle
    b2b_flag = 1'b0;
    for (int n = 0; n < 20; n++) begin
      run_scan(8'd0, b2b_flag, n[0], 1'b1);
      b2b_flag = 1'($urandom_range(0, 1));
      if (!b2b_flag) ack_idle();
    end
    if (b2b_flag) ack_idle();

    // Abort during bit 4
    bus.Start = 1'b1;
    I         = 8'hC3;
    tick();
    bus.Start = 1'b0;
    for (int j = 1; j <= 9; j++) tick();
    chk("pre_abort_S", 32'(bus.S), 32'd4);
    #2 Reset_n = 1'b0;
    #1;
    model_word  = 8'd0;
    last_word   = 8'd0;
    exp_changed = 1'b0;
    check_all("abort", 0, 1'b0, 1'b0);
    tick();
    tick();
    check_all("abort_hold", 0, 1'b0, 1'b0);
    $display("abort S=%0d word=%h valid=%0b busy=%0b", bus.S, bus.Word, bus.Valid, bus.Busy);
    #2 Reset_n = 1'b1;
    tick();

    // Change-detect sequence
    run_scan(8'h5A, 1'b0, 1'b0, 1'b0);
`ifdef MUX8_SCAN_CHANGE_EN
    chk("changed_first", 32'(bus.Changed), 32'd1);
`endif
    ack_idle();
    run_scan(8'h5A, 1'b0, 1'b0, 1'b0);
`ifdef MUX8_SCAN_CHANGE_EN
    chk("changed_same", 32'(bus.Changed), 32'd0);
`endif
    ack_idle();
    run_scan(8'h5B, 1'b0, 1'b0, 1'b0);
`ifdef MUX8_SCAN_CHANGE_EN
    chk("changed_diff", 32'(bus.Changed), 32'd1);
`endif
    chk("final_word", 32'(bus.Word), 32'h 5B);
    ack_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
